spram_march_bist: RTL and testbench

//  Initiator for the 64KB single-port RAM port (addr/data_in/data_out/rdn_wr). On a start pulse it

---
 rtl/spram_march_bist.sv | 126 ++++++++++++
 tb/tb_spram_march_bist.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spram_march_bist.sv
// March C- self-test initiator for a single-port RAM: owns the RAM port while busy,
// reports pass/fail, a saturating error count and the first failing address/data.
module spram_march_bist #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_rdn_wr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] M0_W  = 4'd1;
  localparam logic [3:0] M1_R  = 4'd2;
  localparam logic [3:0] M1_W  = 4'd3;
  localparam logic [3:0] M2_R  = 4'd4;
  localparam logic [3:0] M2_W  = 4'd5;
  localparam logic [3:0] M3_R  = 4'd6;
  localparam logic [3:0] FLUSH = 4'd7;
  localparam logic [3:0] DONE  = 4'd8;

  localparam logic [ADDR_WIDTH-1:0] LAST  = '1;
  localparam logic [DATA_WIDTH-1:0] PAT_N = ~PATTERN;

  // state/addr describe the operation currently driven on the RAM port
  logic [3:0]            state, nstate;
  logic [ADDR_WIDTH-1:0] addr, naddr;
  logic                  nwr, nrd;
  logic [DATA_WIDTH-1:0] nwdata, nexp;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_exp;
  logic                  accept, miscmp;

  always_comb begin
    nstate = state;
    naddr  = addr;
    case (state)
      IDLE:  if (start) begin nstate = M0_W; naddr = '0; end
      M0_W:  if (addr == LAST) begin nstate = M1_R; naddr = '0; end
             else naddr = addr + 1'b1;
      M1_R:  nstate = M1_W;
      M1_W:  if (addr == LAST) nstate = M2_R;
             else begin nstate = M1_R; naddr = addr + 1'b1; end
      M2_R:  nstate = M2_W;
      M2_W:  if (addr == '0) begin nstate = M3_R; naddr = LAST; end
             else begin nstate = M2_R; naddr = addr - 1'b1; end
      M3_R:  if (addr == '0) nstate = FLUSH;
             else naddr = addr - 1'b1;
      FLUSH: nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    nwr    = (nstate == M0_W) || (nstate == M1_W) || (nstate == M2_W);
    nrd    = (nstate == M1_R) || (nstate == M2_R) || (nstate == M3_R);
    nwdata = (nstate == M1_W) ? PAT_N : PATTERN;
    nexp   = (nstate == M2_R) ? PAT_N : PATTERN;
  end

  assign accept   = (state == IDLE) && start;
  // read data belongs to the read issued one edge earlier; addr still holds its address
  assign miscmp   = rd_vld && (ram_rdata != rd_exp);
  assign ram_addr = addr;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state      <= IDLE;
      addr       <= '0;
      ram_rdn_wr <= 1'b0;
      ram_wdata  <= '0;
      rd_vld     <= 1'b0;
      rd_exp     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
    end else begin
      state      <= nstate;
      addr       <= naddr;
      ram_rdn_wr <= nwr;
      ram_wdata  <= nwdata;
      rd_vld     <= nrd;
      rd_exp     <= nexp;
      done       <= (nstate == DONE);
      if (accept) begin
        busy      <= 1'b1;
        pass      <= 1'b0;
        err_cnt   <= '0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end else begin
        if (nstate == DONE) begin
          busy <= 1'b0;
          pass <= (err_cnt == '0);
        end
        if (miscmp) begin
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0) begin
            fail_addr <= addr;
            fail_exp  <= rd_exp;
            fail_got  <= ram_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spram_march_bist.sv
// Scoreboard bench for spram_march_bist on a 16-word RAM model with injectable read faults.
module tb_spram_march_bist;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 16;

  logic          clk, rst_p, start;
  logic          busy, done, pass;
  logic [15:0]   err_cnt;
  logic [AW-1:0] fail_addr, ram_addr;
  logic [DW-1:0] fail_exp, fail_got, ram_wdata, ram_rdata;
  logic          ram_rdn_wr;

  spram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN(8'h55)) dut (
    .clk(clk), .rst_p(rst_p), .start(start),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdn_wr(ram_rdn_wr),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on the rising edge
  logic [DW-1:0] mem [N];
  int            fault_mode;

  always_comb begin
    ram_rdata = mem[ram_addr];
    if (fault_mode == 1 && ram_addr == 4'd5) ram_rdata = mem[ram_addr] | 8'h01;
    if (fault_mode == 2 && (ram_addr == 4'd3 || ram_addr == 4'd9)) ram_rdata = 8'h00;
  end

  always @(posedge clk) if (ram_rdn_wr) mem[ram_addr] <= ram_wdata;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic          flush;
  } op_t;

  typedef struct {
    logic          pass;
    logic [15:0]   err;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fexp;
    logic [DW-1:0] fgot;
  } res_t;

  op_t  op_q[$];
  res_t res_q[$];
  int   total, bad, done_cnt, wr_cnt, rd_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // monitor: every busy cycle shows one RAM op (or the flush cycle); done shows a result
  always @(negedge clk) begin
    if (!rst_p && busy) begin
      if (ram_rdn_wr) wr_cnt++; else rd_cnt++;
      if (op_q.size() == 0) check("op_underflow", 32'(1), 32'(0));
      else begin
        op_t e;
        e = op_q.pop_front();
        check("op_rdn_wr", 32'(ram_rdn_wr), 32'(e.wr));
        if (!e.flush) check("op_addr", 32'(ram_addr), 32'(e.addr));
        if (e.wr) check("op_wdata", 32'(ram_wdata), 32'(e.wdata));
      end
    end
    if (!rst_p && done) begin
      done_cnt++;
      check("done_busy", 32'(busy), 32'(0));
      check("ops_left", 32'(op_q.size()), 32'(0));
      if (res_q.size() == 0) check("res_underflow", 32'(1), 32'(0));
      else begin
        res_t r;
        r = res_q.pop_front();
        check("pass", 32'(pass), 32'(r.pass));
        check("err_cnt", 32'(err_cnt), 32'(r.err));
        check("fail_addr", 32'(fail_addr), 32'(r.faddr));
        check("fail_exp", 32'(fail_exp), 32'(r.fexp));
        check("fail_got", 32'(fail_got), 32'(r.fgot));
      end
    end
  end

  function automatic op_t mk(input int a, input logic w, input logic [DW-1:0] d, input logic f);
    op_t o;
    o.addr = AW'(a); o.wr = w; o.wdata = d; o.flush = f;
    return o;
  endfunction

  function automatic res_t mkr(input logic p, input logic [15:0] e, input logic [AW-1:0] a,
                               input logic [DW-1:0] x, input logic [DW-1:0] g);
    res_t r;
    r.pass = p; r.err = e; r.faddr = a; r.fexp = x; r.fgot = g;
    return r;
  endfunction

  task automatic start_run(input res_t r);
    for (int a = 0; a < N; a++) op_q.push_back(mk(a, 1'b1, 8'h55, 1'b0));
    for (int a = 0; a < N; a++) begin
      op_q.push_back(mk(a, 1'b0, 8'h00, 1'b0));
      op_q.push_back(mk(a, 1'b1, 8'hAA, 1'b0));
    end
    for (int a = N-1; a >= 0; a--) begin
      op_q.push_back(mk(a, 1'b0, 8'h00, 1'b0));
      op_q.push_back(mk(a, 1'b1, 8'h55, 1'b0));
    end
    for (int a = N-1; a >= 0; a--) op_q.push_back(mk(a, 1'b0, 8'h00, 1'b0));
    op_q.push_back(mk(0, 1'b0, 8'h00, 1'b1));
    res_q.push_back(r);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_busy", 32'(busy), 32'(1));
    check("start_clr_pass", 32'(pass), 32'(0));
    check("start_clr_err", 32'(err_cnt), 32'(0));
    check("start_clr_faddr", 32'(fail_addr), 32'(0));
  endtask

  // counts edges after the start edge until done is seen; optional ignored starts
  task automatic wait_done(input logic extra, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (lat > 300) begin
        check("done_timeout", 32'(1), 32'(0));
        break;
      end
      start = (extra && lat == 10);
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
    end
    if (extra) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_pass"}, 32'(pass), 32'(0));
    check({tag, "_err"}, 32'(err_cnt), 32'(0));
    check({tag, "_faddr"}, 32'({fail_addr, fail_exp, fail_got}), 32'(0));
    check({tag, "_raddr"}, 32'(ram_addr), 32'(0));
    check({tag, "_wdata"}, 32'(ram_wdata), 32'(0));
    check({tag, "_rdn_wr"}, 32'(ram_rdn_wr), 32'(0));
  endtask

  res_t clean;
  int   lat, dc;

  initial begin
    total = 0; bad = 0; done_cnt = 0; wr_cnt = 0; rd_cnt = 0;
    fault_mode = 0;
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    rst_p = 1'b1; start = 1'b0;
    clean = mkr(1'b1, 16'd0, 4'd0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_p = 1'b0;
    repeat (2) @(negedge clk);

    // clean run, full op sequence and latency
    start_run(clean);
    wait_done(1'b0, lat);
    check("latency", 32'(lat), 32'(97));
    check("write_count", 32'(wr_cnt), 32'(48));
    check("read_count_plus_flush", 32'(rd_cnt), 32'(49));
    repeat (3) @(negedge clk);
    check("idle_rdn_wr", 32'(ram_rdn_wr), 32'(0));

    // stuck-at-1 on bit0 of word 5: only the ~P read (AA) can fail
    fault_mode = 1;
    start_run(mkr(1'b0, 16'd1, 4'd5, 8'hAA, 8'hAB));
    wait_done(1'b0, lat);
    repeat (2) @(negedge clk);

    // words 3 and 9 read 00: three reads each, first failure is M1 read of word 3
    fault_mode = 2;
    start_run(mkr(1'b0, 16'd6, 4'd3, 8'h55, 8'h00));
    wait_done(1'b0, lat);
    check("hold_err_after_done", 32'(err_cnt), 32'(6));
    repeat (2) @(negedge clk);

    // reset in the middle of the descending march element
    fault_mode = 0;
    dc = done_cnt;
    start_run(clean);
    repeat (60) @(negedge clk);
    #2 rst_p = 1'b1;
    #1 check_reset_outputs("midreset");
    op_q.delete();
    res_q.delete();
    repeat (3) @(negedge clk);
    rst_p = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt), 32'(dc));
    start_run(clean);
    wait_done(1'b0, lat);
    check("rerun_latency", 32'(lat), 32'(97));
    repeat (2) @(negedge clk);

    // starts while busy and in DONE are ignored
    dc = done_cnt;
    start_run(clean);
    wait_done(1'b1, lat);
    repeat (5) @(negedge clk);
    check("extra_start_busy", 32'(busy), 32'(0));
    check("extra_start_one_done", 32'(done_cnt), 32'(dc + 1));
    check("extra_start_ops_left", 32'(op_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
